// File: rtl/wb_axi_pkg.sv
// Shared AXI4-Lite definitions for the WB bridge and its downstream slaves.
// Response codes plus the slave channel state encodings.
package wb_axi_pkg;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_RESP
  } r_state_e;

endpackage

// File: rtl/axi4lite_reg_slave_if.sv
// AXI4-Lite bus bundle between the WB bridge master and the register slave.
// The master drives requests; the slave drives readies and responses.
interface axi4lite_reg_slave_if #(
  parameter int DW = 32,
  parameter int AW = 32
);

  logic            awvalid;
  logic            awready;
  logic [AW-1:0]   awaddr;
  logic [2:0]      awprot;
  logic            wvalid;
  logic            wready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            bvalid;
  logic            bready;
  logic [1:0]      bresp;
  logic            arvalid;
  logic            arready;
  logic [AW-1:0]   araddr;
  logic [2:0]      arprot;
  logic            rvalid;
  logic            rready;
  logic [DW-1:0]   rdata;
  logic [1:0]      rresp;

  modport master (
    output awvalid, awaddr, awprot,
    output wvalid, wdata, wstrb,
    output bready,
    output arvalid, araddr, arprot,
    output rready,
    input  awready, wready,
    input  bvalid, bresp,
    input  arready,
    input  rvalid, rdata, rresp
  );

  modport slave (
    input  awvalid, awaddr, awprot,
    input  wvalid, wdata, wstrb,
    input  bready,
    input  arvalid, araddr, arprot,
    input  rready,
    output awready, wready,
    output bvalid, bresp,
    output arready,
    output rvalid, rdata, rresp
  );

endinterface

// File: rtl/axi4lite_aw_w_join.sv
// Joins independent AW and W beats into one write commit strobe.
// Whichever beat arrives first is held until its partner shows up.
module axi4lite_aw_w_join #(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int IW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rdy_en,
  input  logic            bvalid,
  input  logic            awvalid,
  input  logic [AW-1:0]   awaddr,
  input  logic            wvalid,
  input  logic [DW-1:0]   wdata,
  input  logic [DW/8-1:0] wstrb,
  output logic            awready,
  output logic            wready,
  output logic            commit,
  output logic [IW-1:0]   idx,
  output logic [DW-1:0]   data,
  output logic [DW/8-1:0] strb,
  output logic            err
);

  logic            aw_held;
  logic            w_held;
  logic [AW-1:0]   aw_q;
  logic [DW-1:0]   data_q;
  logic [DW/8-1:0] strb_q;
  logic            aw_fire;
  logic            w_fire;
  logic [AW-1:0]   addr;
  logic            unused_ok;

  assign awready = rdy_en & ~aw_held & ~bvalid;
  assign wready  = rdy_en & ~w_held & ~bvalid;
  assign aw_fire = awvalid & awready;
  assign w_fire  = wvalid & wready;
  assign commit  = (aw_held | aw_fire) & (w_held | w_fire);

  assign addr = aw_held ? aw_q : awaddr;
  assign data = w_held ? data_q : wdata;
  assign strb = w_held ? strb_q : wstrb;
  assign idx  = addr[IW+1:2];
  assign err  = |addr[AW-1:IW+2];

  // byte offset within a word carries no meaning here
  assign unused_ok = ^addr[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_q    <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else begin
      if (aw_fire) aw_q <= awaddr;
      if (w_fire) begin
        data_q <= wdata;
        strb_q <= wstrb;
      end
      aw_held <= ~commit & (aw_held | aw_fire);
      w_held  <= ~commit & (w_held | w_fire);
    end
  end

endmodule

// File: rtl/axi4lite_reg_slave.sv
// AXI4-Lite register bank: byte-strobed RW slots, read-only hardware slots,
// one outstanding write and one outstanding read, SLVERR beyond the bank.
module axi4lite_reg_slave
  import wb_axi_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32,
  parameter int NREGS = 16,
  parameter logic [NREGS-1:0] RO_MASK = '0
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  axi4lite_reg_slave_if.slave s_axi,
  output logic [NREGS*DW-1:0] reg_o,
  input  logic [NREGS*DW-1:0] reg_i,
  output logic [NREGS-1:0]    wr_pulse_o
);

  localparam int IW = $clog2(NREGS);

  logic            rdy_en;
  logic            commit;
  logic [IW-1:0]   w_idx;
  logic [DW-1:0]   w_data;
  logic [DW/8-1:0] w_strb;
  logic            w_err;
  logic            wr_ok;
  logic [DW-1:0]   regs_q [NREGS];
  logic [1:0]      bresp_q;
  logic [NREGS-1:0] pulse_q;
  w_state_e        w_q, w_d;
  r_state_e        r_q, r_d;
  logic            ar_fire;
  logic [IW-1:0]   r_idx;
  logic            r_err;
  logic [DW-1:0]   rd_val;
  logic [DW-1:0]   rdata_q;
  logic [1:0]      rresp_q;
  logic            unused_ok;

  assign unused_ok = ^{s_axi.awprot, s_axi.arprot, s_axi.araddr[1:0]};

  // holds every ready low for one cycle after reset release
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) rdy_en <= 1'b0;
    else            rdy_en <= 1'b1;
  end

  axi4lite_aw_w_join #(
    .DW(DW),
    .AW(AW),
    .IW(IW)
  ) u_join (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_ni),
    .rdy_en (rdy_en),
    .bvalid (s_axi.bvalid),
    .awvalid(s_axi.awvalid),
    .awaddr (s_axi.awaddr),
    .wvalid (s_axi.wvalid),
    .wdata  (s_axi.wdata),
    .wstrb  (s_axi.wstrb),
    .awready(s_axi.awready),
    .wready (s_axi.wready),
    .commit (commit),
    .idx    (w_idx),
    .data   (w_data),
    .strb   (w_strb),
    .err    (w_err)
  );

  assign wr_ok = commit & ~w_err & ~RO_MASK[w_idx];

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      bresp_q <= AXI_RESP_OKAY;
      pulse_q <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        for (int k = 0; k < DW/8; k++)
          if (wr_ok && w_idx == IW'(i) && w_strb[k])
            regs_q[i][8*k +: 8] <= w_data[8*k +: 8];
      if (commit) bresp_q <= w_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      pulse_q <= wr_ok ? (NREGS'(1) << w_idx) : '0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) w_q <= W_IDLE;
    else            w_q <= w_d;
  end

  always_comb begin
    w_d = w_q;
    unique case (w_q)
      W_IDLE: if (commit) w_d = W_RESP;
      W_RESP: if (s_axi.bready) w_d = W_IDLE;
      default: w_d = W_IDLE;
    endcase
  end

  assign s_axi.bvalid = (w_q == W_RESP);
  assign s_axi.bresp  = bresp_q;

  assign s_axi.arready = rdy_en & ~s_axi.rvalid;
  assign ar_fire = s_axi.arvalid & s_axi.arready;
  assign r_idx   = s_axi.araddr[IW+1:2];
  assign r_err   = |s_axi.araddr[AW-1:IW+2];

  always_comb begin
    rd_val = '0;
    if (!r_err)
      rd_val = RO_MASK[r_idx] ? reg_i[int'(r_idx)*DW +: DW] : regs_q[r_idx];
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      r_q     <= R_IDLE;
      rdata_q <= '0;
      rresp_q <= AXI_RESP_OKAY;
    end else begin
      r_q <= r_d;
      if (ar_fire) begin
        rdata_q <= rd_val;
        rresp_q <= r_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      end
    end
  end

  always_comb begin
    r_d = r_q;
    unique case (r_q)
      R_IDLE: if (ar_fire) r_d = R_RESP;
      R_RESP: if (s_axi.rready) r_d = R_IDLE;
      default: r_d = R_IDLE;
    endcase
  end

  assign s_axi.rvalid = (r_q == R_RESP);
  assign s_axi.rdata  = rdata_q;
  assign s_axi.rresp  = rresp_q;

  always_comb begin
    reg_o = '0;
    for (int i = 0; i < NREGS; i++) reg_o[i*DW +: DW] = regs_q[i];
  end

  assign wr_pulse_o = pulse_q;

endmodule

// File: tb/tb_axi4lite_reg_slave.sv
// Randomized self-checking bench for axi4lite_reg_slave against an
// array-based model of the register bank.
module tb_axi4lite_reg_slave;

  localparam logic [15:0] ROM = 16'h0088;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [511:0] reg_o;
  logic [511:0] reg_i;
  logic [15:0]  wr_pulse_o;

  int checks = 0;
  int errors = 0;
  logic [31:0] model [16];

  axi4lite_reg_slave_if #(.DW(32), .AW(32)) s_axi ();

  axi4lite_reg_slave #(
    .DW(32), .AW(32), .NREGS(16), .RO_MASK(ROM)
  ) dut (
    .wb_clk_i  (clk),
    .wb_rst_ni (rst_n),
    .s_axi     (s_axi),
    .reg_o     (reg_o),
    .reg_i     (reg_i),
    .wr_pulse_o(wr_pulse_o)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [511:0] model_flat();
    logic [511:0] f;
    for (int i = 0; i < 16; i++) f[i*32 +: 32] = model[i];
    return f;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp,
                             output logic [15:0] pls);
    int i;
    pls = '0;
    if (a >= 32'h40) begin
      resp = 2'b10;
    end else begin
      resp = 2'b00;
      i = int'(a[5:2]);
      if (!ROM[i]) begin
        for (int k = 0; k < 4; k++)
          if (s[k]) model[i][8*k +: 8] = d[8*k +: 8];
        pls[i] = 1'b1;
      end
    end
  endtask

  task automatic model_read(input logic [31:0] a, output logic [31:0] d,
                            output logic [1:0] resp);
    int i;
    if (a >= 32'h40) begin
      d = '0;
      resp = 2'b10;
    end else begin
      i = int'(a[5:2]);
      resp = 2'b00;
      d = ROM[i] ? reg_i[i*32 +: 32] : model[i];
    end
  endtask

  task automatic aw_chan(input logic [31:0] a);
    int n = 0;
    s_axi.awvalid = 1'b1;
    s_axi.awaddr  = a;
    while (!s_axi.awready && n < 40) begin @(negedge clk); n++; end
    if (!s_axi.awready) begin
      checks++; errors++;
      $display("FAIL aw_timeout: awready=%0b required 1", s_axi.awready);
    end
    @(posedge clk); #1;
    s_axi.awvalid = 1'b0;
  endtask

  task automatic w_chan(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    s_axi.wvalid = 1'b1;
    s_axi.wdata  = d;
    s_axi.wstrb  = s;
    while (!s_axi.wready && n < 40) begin @(negedge clk); n++; end
    if (!s_axi.wready) begin
      checks++; errors++;
      $display("FAIL w_timeout: wready=%0b required 1", s_axi.wready);
    end
    @(posedge clk); #1;
    s_axi.wvalid = 1'b0;
  endtask

  task automatic ar_chan(input logic [31:0] a);
    int n = 0;
    s_axi.arvalid = 1'b1;
    s_axi.araddr  = a;
    while (!s_axi.arready && n < 40) begin @(negedge clk); n++; end
    if (!s_axi.arready) begin
      checks++; errors++;
      $display("FAIL ar_timeout: arready=%0b required 1", s_axi.arready);
    end
    @(posedge clk); #1;
    s_axi.arvalid = 1'b0;
  endtask

  task automatic b_ack(output logic [1:0] resp);
    int n = 0;
    @(negedge clk);
    while (!s_axi.bvalid && n < 40) begin @(negedge clk); n++; end
    if (!s_axi.bvalid) begin
      checks++; errors++;
      $display("FAIL b_timeout: bvalid=%0b required 1", s_axi.bvalid);
    end
    resp = s_axi.bresp;
    s_axi.bready = 1'b1;
    @(posedge clk); #1;
    s_axi.bready = 1'b0;
    @(negedge clk);
  endtask

  task automatic r_ack(output logic [31:0] d, output logic [1:0] resp);
    int n = 0;
    @(negedge clk);
    while (!s_axi.rvalid && n < 40) begin @(negedge clk); n++; end
    if (!s_axi.rvalid) begin
      checks++; errors++;
      $display("FAIL r_timeout: rvalid=%0b required 1", s_axi.rvalid);
    end
    d = s_axi.rdata;
    resp = s_axi.rresp;
    s_axi.rready = 1'b1;
    @(posedge clk); #1;
    s_axi.rready = 1'b0;
    @(negedge clk);
  endtask

  task automatic write_txn(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input int ad, input int wd,
                           output logic bv, output logic [1:0] resp,
                           output logic [15:0] pls, output logic [15:0] pls_after);
    fork
      begin repeat (ad) @(negedge clk); aw_chan(a); end
      begin repeat (wd) @(negedge clk); w_chan(d, s); end
    join
    @(negedge clk);
    bv  = s_axi.bvalid;
    pls = wr_pulse_o;
    b_ack(resp);
    pls_after = wr_pulse_o;
  endtask

  task automatic read_txn(input logic [31:0] a, output logic [31:0] d,
                          output logic [1:0] resp);
    ar_chan(a);
    r_ack(d, resp);
  endtask

  task automatic check_write(input string nm, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] s,
                             input int ad, input int wd);
    logic bv;
    logic [1:0] resp, eresp;
    logic [15:0] pls, pa, epls;
    write_txn(a, d, s, ad, wd, bv, resp, pls, pa);
    model_write(a, d, s, eresp, epls);
    checks++;
    if (bv !== 1'b1) begin
      errors++;
      $display("FAIL %s_bvalid_latency: got %0b required 1", nm, bv);
    end
    checks++;
    if (resp !== eresp) begin
      errors++;
      $display("FAIL %s_bresp: addr %h got %b required %b", nm, a, resp, eresp);
    end
    checks++;
    if (pls !== epls || pa !== 16'h0) begin
      errors++;
      $display("FAIL %s_pulse: got %h then %h required %h then 0", nm, pls, pa, epls);
    end
    checks++;
    if (reg_o !== model_flat()) begin
      errors++;
      $display("FAIL %s_regs: addr %h reg_o %h required %h", nm, a, reg_o, model_flat());
    end
  endtask

  task automatic check_read(input string nm, input logic [31:0] a);
    logic [31:0] d, ed;
    logic [1:0] r, er;
    read_txn(a, d, r);
    model_read(a, ed, er);
    checks++;
    if (d !== ed || r !== er) begin
      errors++;
      $display("FAIL %s_read: addr %h got %h/%b required %h/%b", nm, a, d, r, ed, er);
    end
  endtask

  task automatic release_and_check(input string nm);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_axi.awready, s_axi.wready, s_axi.arready} !== 3'b000) begin
      errors++;
      $display("FAIL %s_ready_first_cycle: got %b required 000", nm,
               {s_axi.awready, s_axi.wready, s_axi.arready});
    end
    @(negedge clk);
    checks++;
    if ({s_axi.awready, s_axi.wready, s_axi.arready} !== 3'b111) begin
      errors++;
      $display("FAIL %s_ready_second_cycle: got %b required 111", nm,
               {s_axi.awready, s_axi.wready, s_axi.arready});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({s_axi.awready, s_axi.wready, s_axi.arready, s_axi.bvalid, s_axi.rvalid} !== 5'b0 ||
        s_axi.bresp !== 2'b00 || s_axi.rresp !== 2'b00 || s_axi.rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus: rdy %b bv %b rv %b bresp %b rresp %b rdata %h required all 0",
               {s_axi.awready, s_axi.wready, s_axi.arready}, s_axi.bvalid, s_axi.rvalid,
               s_axi.bresp, s_axi.rresp, s_axi.rdata);
    end
    checks++;
    if (reg_o !== 512'h0 || wr_pulse_o !== 16'h0) begin
      errors++;
      $display("FAIL reset_regs: reg_o %h pulse %h required 0", reg_o, wr_pulse_o);
    end
    release_and_check("reset");
  endtask

  task automatic test_same_cycle();
    check_write("same_cycle", 32'h08, 32'hDEADBEEF, 4'hF, 0, 0);
  endtask

  task automatic test_w_first();
    logic [1:0] resp, eresp;
    logic [15:0] epls;
    w_chan(32'h11223344, 4'h3);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (s_axi.wready !== 1'b0 || s_axi.awready !== 1'b1) begin
        errors++;
        $display("FAIL w_first_ready: wready %b awready %b required 0 1",
                 s_axi.wready, s_axi.awready);
      end
    end
    aw_chan(32'h08);
    model_write(32'h08, 32'h11223344, 4'h3, eresp, epls);
    @(negedge clk);
    checks++;
    if (s_axi.bvalid !== 1'b1 || wr_pulse_o !== epls) begin
      errors++;
      $display("FAIL w_first_commit: bvalid %b pulse %h required 1 %h",
               s_axi.bvalid, wr_pulse_o, epls);
    end
    b_ack(resp);
    checks++;
    if (resp !== eresp || reg_o[64 +: 32] !== 32'hDEAD3344) begin
      errors++;
      $display("FAIL w_first_data: bresp %b slot2 %h required %b DEAD3344",
               resp, reg_o[64 +: 32], eresp);
    end
  endtask

  task automatic test_out_of_range();
    check_write("oor", 32'h40, 32'h12345678, 4'hF, 0, 1);
    check_read("oor", 32'h40);
  endtask

  task automatic test_ro();
    check_write("ro", 32'h0C, 32'h87654321, 4'hF, 1, 0);
    check_read("ro", 32'h0C);
  endtask

  task automatic test_same_edge();
    logic [31:0] d, ed;
    logic [1:0] r, er, br, ebr;
    logic [15:0] epls;
    model_read(32'h04, ed, er);
    fork
      aw_chan(32'h04);
      w_chan(32'h0000005A, 4'hF);
      ar_chan(32'h04);
    join
    model_write(32'h04, 32'h0000005A, 4'hF, ebr, epls);
    r_ack(d, r);
    b_ack(br);
    checks++;
    if (d !== ed || r !== er || br !== ebr) begin
      errors++;
      $display("FAIL same_edge_old: rdata %h rresp %b bresp %b required %h %b %b",
               d, r, br, ed, er, ebr);
    end
    check_read("same_edge_new", 32'h04);
  endtask

  task automatic test_b_stall();
    logic [1:0] r0, r, er;
    logic [15:0] epls;
    logic [31:0] d, ed;
    logic [1:0] rr, err_r;
    fork
      aw_chan(32'h3C);
      w_chan(32'hA5A5F00D, 4'hF);
    join
    model_write(32'h3C, 32'hA5A5F00D, 4'hF, er, epls);
    @(negedge clk);
    r0 = s_axi.bresp;
    repeat (5) begin
      checks++;
      if (s_axi.bvalid !== 1'b1 || s_axi.bresp !== er ||
          s_axi.awready !== 1'b0 || s_axi.wready !== 1'b0) begin
        errors++;
        $display("FAIL b_stall_hold: bv %b bresp %b awr %b wr %b required 1 %b 0 0",
                 s_axi.bvalid, s_axi.bresp, s_axi.awready, s_axi.wready, er);
      end
      @(negedge clk);
    end
    read_txn(32'h3C, d, rr);
    model_read(32'h3C, ed, err_r);
    checks++;
    if (d !== ed || rr !== err_r || s_axi.bvalid !== 1'b1 || s_axi.bresp !== r0) begin
      errors++;
      $display("FAIL b_stall_read: rdata %h rresp %b bv %b required %h %b 1",
               d, rr, s_axi.bvalid, ed, err_r);
    end
    b_ack(r);
    checks++;
    if (r !== er) begin
      errors++;
      $display("FAIL b_stall_resp: got %b required %b", r, er);
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) a = $urandom | 32'h40;
      else a = {26'h0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 0)
        check_write("rand_wr", a, $urandom, 4'($urandom_range(0, 15)),
                    $urandom_range(0, 3), $urandom_range(0, 3));
      else
        check_read("rand_rd", a);
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] br, ebr;
    logic [15:0] epls;
    int n = 0;
    ar_chan(32'h3C);
    @(negedge clk);
    while (!s_axi.rvalid && n < 20) begin @(negedge clk); n++; end
    aw_chan(32'h10);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (s_axi.rvalid !== 1'b0 || s_axi.bvalid !== 1'b0 || reg_o !== 512'h0 ||
        {s_axi.awready, s_axi.wready, s_axi.arready} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_async: rv %b bv %b rdy %b reg_o %h required 0",
               s_axi.rvalid, s_axi.bvalid,
               {s_axi.awready, s_axi.wready, s_axi.arready}, reg_o);
    end
    for (int i = 0; i < 16; i++) model[i] = '0;
    repeat (2) @(posedge clk);
    release_and_check("reset_mid");
    w_chan(32'h0000C0DE, 4'hF);
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (s_axi.bvalid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_stale_aw: bvalid %b required 0", s_axi.bvalid);
      end
    end
    aw_chan(32'h10);
    model_write(32'h10, 32'h0000C0DE, 4'hF, ebr, epls);
    b_ack(br);
    checks++;
    if (br !== ebr || reg_o !== model_flat()) begin
      errors++;
      $display("FAIL reset_mid_after: bresp %b reg_o %h required %b %h",
               br, reg_o, ebr, model_flat());
    end
  endtask

  initial begin
    s_axi.awvalid = 1'b0;
    s_axi.awaddr  = '0;
    s_axi.awprot  = '0;
    s_axi.wvalid  = 1'b0;
    s_axi.wdata   = '0;
    s_axi.wstrb   = '0;
    s_axi.bready  = 1'b0;
    s_axi.arvalid = 1'b0;
    s_axi.araddr  = '0;
    s_axi.arprot  = '0;
    s_axi.rready  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      reg_i[i*32 +: 32] = $urandom;
      model[i] = '0;
    end
    reg_i[96 +: 32] = 32'hCAFE0001;

    test_reset();
    test_same_cycle();
    test_w_first();
    test_out_of_range();
    test_ro();
    test_same_edge();
    test_b_stall();
    test_random();
    test_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
